// File: rtl/sc_dot_product_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic dot-product controller:
//   - state_e       : controller states (IDLE, LOAD, RUN, DRAIN, DONE)
//   - LFSR_W/TAPS   : 16-bit maximal Fibonacci LFSR, taps 16,14,13,11
//   - COUNT_EXTRA   : extra count bits above STREAM_BITS (1 unipolar, 2 bipolar)
//   - clogb2()      : ceil(log2(value)), never less than 1
// Optional feature macro: SC_DOT_PRODUCT_CTRL_BIPOLAR_EN selects the signed
// bipolar count encoding (2*ones - N) instead of the plain ones count.
// -----------------------------------------------------------------------------
package sc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

`ifdef SC_DOT_PRODUCT_CTRL_BIPOLAR_EN
  localparam int COUNT_EXTRA = 2;
`else
  localparam int COUNT_EXTRA = 1;
`endif

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sc_dot_product_ctrl_if.sv
// -----------------------------------------------------------------------------
// sc_dot_product_ctrl_if
// Host-side handshake bundle of the controller.
//   start_valid/start_ready : operation request handshake
//   count/count_valid/count_ready : result handshake
//   busy                    : controller not idle
// Modports: master = host, slave = controller.
// -----------------------------------------------------------------------------
interface sc_dot_product_ctrl_if #(
  parameter int COUNT_W = 5
);
  logic               start_valid;
  logic               start_ready;
  logic [COUNT_W-1:0] count;
  logic               count_valid;
  logic               count_ready;
  logic               busy;

  modport master (
    output start_valid, count_ready,
    input  start_ready, count, count_valid, busy
  );

  modport slave (
    input  start_valid, count_ready,
    output start_ready, count, count_valid, busy
  );
endinterface

// File: rtl/sc_dot_product_ctrl_lfsr.sv
// -----------------------------------------------------------------------------
// sc_lfsr
// Fibonacci LFSR, shifts towards the MSB with the XOR of the tapped bits
// entering at bit 0. Holds its value while i_advance is low.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (loads SEED)
//   i_advance  : step the register this cycle
//   o_bits     : low OUT_W bits of the register
// -----------------------------------------------------------------------------
module sc_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int               OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_advance,
  output logic [OUT_W-1:0] o_bits
);

  logic [WIDTH-1:0] r_state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_advance) begin
      r_state <= {r_state[WIDTH-2:0], ^(r_state & TAPS)};
    end
  end

  assign o_bits = r_state[OUT_W-1:0];

endmodule

// File: rtl/sc_dot_product_ctrl.sv
// -----------------------------------------------------------------------------
// sc_dot_product_ctrl
// Sequencer for the stochastic dot-product datapath: on a start request it
// pulses sng_load, enables the stream generators for N = 2**STREAM_BITS
// cycles, supplies the LFSR adder-select stream, counts 1s on dp_result in a
// window delayed by PIPE_LAT cycles, and returns the count via valid/ready.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   host (slave)      : start_valid/start_ready, count/count_valid/count_ready, busy
//   sng_load          : one-cycle operand load pulse
//   sng_en            : stream generator enable (N cycles)
//   sel               : adder select stream, clogb2(LENGTH) bits
//   dp_result/dp_valid: dot-product output stream
// Optional feature macro: SC_DOT_PRODUCT_CTRL_BIPOLAR_EN -> count is signed
// 2*ones - N on STREAM_BITS+2 bits; otherwise the unsigned ones count.
// -----------------------------------------------------------------------------
module sc_dot_product_ctrl
  import sc_pkg::*;
#(
  parameter int                LENGTH      = 4,
  parameter int                STREAM_BITS = 8,
  parameter int                PIPE_LAT    = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  sc_dot_product_ctrl_if.slave       host,
  output logic                       sng_load,
  output logic                       sng_en,
  output logic [clogb2(LENGTH)-1:0]  sel,
  input  logic                       dp_result,
  input  logic                       dp_valid
);

  localparam int SELECT_WIDTH = clogb2(LENGTH);
  localparam int N            = 1 << STREAM_BITS;
  localparam int COUNT_W      = STREAM_BITS + COUNT_EXTRA;
  localparam int DRAIN_W      = clogb2(PIPE_LAT);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_LOAD  = LOAD;
  localparam logic [2:0] ST_RUN   = RUN;
  localparam logic [2:0] ST_DRAIN = DRAIN;
  localparam logic [2:0] ST_DONE  = DONE;

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [STREAM_BITS-1:0] r_stream_cnt;
  logic [DRAIN_W-1:0]     r_drain_cnt;
  logic [STREAM_BITS:0]   r_acc;
  logic [PIPE_LAT-1:0]    r_sample_sr;
  logic                   w_sample_en;
  logic                   w_busy;
  logic                   w_run_last;
  logic                   w_drain_last;
  logic [COUNT_W-1:0]     w_count_val;

  assign w_run_last   = (r_stream_cnt == STREAM_BITS'(N - 1));
  assign w_drain_last = (r_drain_cnt == DRAIN_W'(PIPE_LAT - 1));
  assign w_busy       = (r_state != ST_IDLE);
  // sng_en delayed by PIPE_LAT cycles lines each input bit up with its result bit.
  assign w_sample_en  = r_sample_sr[PIPE_LAT-1];

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (host.start_valid) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_run_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (host.count_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_stream_cnt <= '0;
      r_drain_cnt  <= '0;
      r_acc        <= '0;
      r_sample_sr  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == ST_LOAD) begin
        r_stream_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_stream_cnt <= r_stream_cnt + STREAM_BITS'(1);
      end

      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;

      r_sample_sr[0] <= sng_en;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_sample_sr[i] <= r_sample_sr[i-1];
      end

      // The window has always drained by LOAD, so clearing here never drops a sample.
      if (r_state == ST_LOAD) begin
        r_acc <= '0;
      end else if (w_sample_en && dp_valid && dp_result) begin
        r_acc <= r_acc + (STREAM_BITS + 1)'(1);
      end
    end
  end

`ifdef SC_DOT_PRODUCT_CTRL_BIPOLAR_EN
  assign w_count_val = {r_acc, 1'b0} - COUNT_W'(N);
`else
  assign w_count_val = r_acc;
`endif

  assign sng_load         = (r_state == ST_LOAD);
  assign sng_en           = (r_state == ST_RUN);
  assign host.start_ready = (r_state == ST_IDLE);
  assign host.busy        = w_busy;
  assign host.count_valid = (r_state == ST_DONE);
  // Gated so only a finished count is ever visible; reads 0 otherwise.
  assign host.count       = (r_state == ST_DONE) ? w_count_val : '0;

  sc_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS),
    .OUT_W (SELECT_WIDTH)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_busy),
    .o_bits    (sel)
  );

endmodule

// File: tb/tb_sc_dot_product_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sc_dot_product_ctrl
// Randomised and directed operations against a cycle-indexed reference model:
// the expected count is the number of cycles in the sample window where the
// bench drove dp_valid & dp_result. Expected counts go into a queue; a monitor
// pops and compares whenever count_valid & count_ready are both high.
// -----------------------------------------------------------------------------
module tb_sc_dot_product_ctrl;
  import sc_pkg::*;

  localparam int SB      = 4;
  localparam int N       = 1 << SB;
  localparam int PL      = 2;
  localparam int LEN     = 4;
  localparam int SEL_W   = clogb2(LEN);
  localparam int COUNT_W = SB + COUNT_EXTRA;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int W0      = 2 + PL;       // first sample cycle after the start edge
  localparam int W1      = N + 1 + PL;   // last sample cycle
  localparam int LAST    = N + PL + 2;   // first count_valid cycle

  logic             clk;
  logic             rst;
  logic             sng_load;
  logic             sng_en;
  logic [SEL_W-1:0] sel;
  logic             dp_result;
  logic             dp_valid;

  sc_dot_product_ctrl_if #(.COUNT_W(COUNT_W)) host_if ();

  sc_dot_product_ctrl #(
    .LENGTH      (LEN),
    .STREAM_BITS (SB),
    .PIPE_LAT    (PL),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host_if),
    .sng_load  (sng_load),
    .sng_en    (sng_en),
    .sel       (sel),
    .dp_result (dp_result),
    .dp_valid  (dp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // sel statistics and log, gathered while busy
  int busy_cycles = 0;
  int sel_ones[SEL_W];
  int sel_log[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_val();
`ifdef SC_DOT_PRODUCT_CTRL_BIPOLAR_EN
    return int'($signed(host_if.count));
`else
    return int'(host_if.count);
`endif
  endfunction

  function automatic int model_count(input int ones);
`ifdef SC_DOT_PRODUCT_CTRL_BIPOLAR_EN
    return 2 * ones - N;
`else
    return ones;
`endif
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && host_if.count_valid === 1'b1 && host_if.count_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: count %0d presented with nothing expected", count_val());
      end else begin
        check("scoreboard", count_val(), exp_q.pop_front());
      end
    end
  end

  // sel sampler
  always @(negedge clk) begin
    if (rst === 1'b0 && host_if.busy === 1'b1) begin
      busy_cycles++;
      for (int b = 0; b < SEL_W; b++) sel_ones[b] += int'(sel[b]);
      if (sel_log.size() < 64) sel_log.push_back(int'(sel));
    end
  end

  task automatic clear_sel_stats();
    busy_cycles = 0;
    for (int b = 0; b < SEL_W; b++) sel_ones[b] = 0;
    sel_log.delete();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    host_if.start_valid = 1'b0;
    host_if.count_ready = 1'b0;
    #1;
    check("reset_outputs", {sng_load, sng_en, host_if.count_valid, host_if.start_ready, host_if.busy}, 5'b00010);
    check("reset_count", count_val(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode: 0 random, 1 all ones, 2 alternating in window, 3 dp_valid low 3 window cycles
  task automatic run_op(input int mode, input int hold, input int abort_at, input bit hold_start);
    int res[64];
    int val[64];
    int ones;
    int expv;
    ones = 0;
    for (int c = 0; c < 64; c++) begin
      res[c] = int'($urandom_range(0, 1));
      val[c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if (mode != 0) begin
        res[c] = 1;
        val[c] = 1;
      end
      if (mode == 2 && c >= W0 && c <= W1) res[c] = ((c - W0) % 2 == 0) ? 1 : 0;
      if (mode == 3 && c >= W0 + 2 && c <= W0 + 4) val[c] = 0;
      if (c >= W0 && c <= W1 && res[c] == 1 && val[c] == 1) ones++;
    end
    expv = model_count(ones);
    if (abort_at == 0) exp_q.push_back(expv);

    #1 host_if.start_valid = 1'b1;
    @(posedge clk);  // start edge
    for (int c = 1; c <= LAST; c++) begin
      #1;
      host_if.start_valid = hold_start;
      dp_result = res[c][0];
      dp_valid  = val[c][0];
      host_if.count_ready = (c == LAST && hold == 0);
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("abort_outputs", {sng_en, host_if.count_valid, host_if.busy, host_if.start_ready}, 4'b0001);
        check("abort_count", count_val(), 0);
        host_if.start_valid = 1'b0;
        host_if.count_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      @(negedge clk);
      check($sformatf("timing_c%0d", c),
            {sng_load, sng_en, host_if.count_valid, host_if.start_ready, host_if.busy},
            {(c == 1), (c >= 2 && c <= N + 1), (c == LAST), 1'b0, 1'b1});
      if (c == LAST) check("done_count", count_val(), expv);
      @(posedge clk);
    end
    for (int h = 1; h <= hold; h++) begin
      #1;
      host_if.count_ready = (h == hold);
      dp_result = res[LAST + h][0];
      dp_valid  = val[LAST + h][0];
      @(negedge clk);
      check("hold_state", {sng_load, host_if.count_valid, host_if.start_ready, host_if.busy}, 4'b0101);
      check("hold_count", count_val(), expv);
      @(posedge clk);
    end
    #1;
    host_if.count_ready = 1'b0;
    host_if.start_valid = 1'b0;
    @(negedge clk);
    check("idle_after_transfer",
          {sng_load, sng_en, host_if.count_valid, host_if.start_ready, host_if.busy}, 5'b00010);
    check("idle_count", count_val(), 0);
    @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_a[$];
    int ok;
    rst = 1'b1;
    host_if.start_valid = 1'b0;
    host_if.count_ready = 1'b0;
    dp_result = 1'b0;
    dp_valid  = 1'b0;
    for (int b = 0; b < SEL_W; b++) sel_ones[b] = 0;

    do_reset();
    clear_sel_stats();
    run_op(1, 0, 0, 1'b0);                        // all ones -> N
    check("sel_first_is_seed", (sel_log.size() > 0) ? sel_log[0] : -1, int'(SEED[SEL_W-1:0]));
    seq_a = sel_log;

    do_reset();
    clear_sel_stats();
    run_op(0, 1, 0, 1'b0);                        // random
    for (int i = 0; i < 20; i++)
      check($sformatf("sel_repeat_%0d", i), (i < sel_log.size()) ? sel_log[i] : -1, seq_a[i]);

    run_op(2, 0, 0, 1'b0);                        // alternating -> N/2
    run_op(3, 2, 0, 1'b0);                        // 3 invalid samples -> N-3
    run_op(1, 5, 0, 1'b1);                        // held count_ready, start_valid ignored
    run_op(1, 0, 10, 1'b0);                       // reset in RUN cycle 10
    run_op(1, 0, 0, 1'b0);                        // recovers -> N

    do_reset();
    clear_sel_stats();
    for (int k = 0; k < 230; k++) run_op(0, int'($urandom_range(0, 3)), 0, 1'b0);

    check("sel_busy_cycles_enough", (busy_cycles >= 4096) ? 1 : 0, 1);
    for (int b = 0; b < SEL_W; b++) begin
      ok = (sel_ones[b] * 100 >= busy_cycles * 45 && sel_ones[b] * 100 <= busy_cycles * 55) ? 1 : 0;
      if (ok == 0) $display("sel bit %0d ones %0d of %0d", b, sel_ones[b], busy_cycles);
      check($sformatf("sel_bit%0d_fraction", b), ok, 1);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
